// File: rtl/text_line_renderer_if.sv
// ============================================================================
// Module      : text_line_renderer_if
// Description : Scanline request, glyph ROM and pixel stream signals of the
//               text line renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface text_line_renderer_if #(
    parameter int NUM_CHARS = 8
);
    logic                   LINE_START;
    logic [3:0]             GLYPH_ROW;
    logic [4*NUM_CHARS-1:0] CHAR_CODES;
    logic [7:0]             FONT_ADDR;
    logic [7:0]             FONT_DATA;
    logic                   FETCH_BUSY;
    logic                   LINE_READY;
    logic                   PIXEL_EN;
    logic                   PIXEL_ON;
    logic                   LINE_DONE;

    modport master (
        output LINE_START, GLYPH_ROW, CHAR_CODES, FONT_DATA, PIXEL_EN,
        input  FONT_ADDR, FETCH_BUSY, LINE_READY, PIXEL_ON, LINE_DONE
    );

    modport slave (
        input  LINE_START, GLYPH_ROW, CHAR_CODES, FONT_DATA, PIXEL_EN,
        output FONT_ADDR, FETCH_BUSY, LINE_READY, PIXEL_ON, LINE_DONE
    );
endinterface

`default_nettype wire

// File: rtl/text_line_renderer.sv
// ============================================================================
// Module      : text_line_renderer
// Description : Fetches one glyph row per character into a line buffer, then
//               shifts the scanline out one pixel per PIXEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_line_renderer #(
    parameter int NUM_CHARS = 8
) (
    input  wire logic           Clk,
    input  wire logic           Reset,
    text_line_renderer_if.slave bus
);

    localparam int IW   = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int NPIX = 8 * NUM_CHARS;
    localparam int PW   = $clog2(NPIX);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHARS - 1);
    localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [PW-1:0]   pix_q;
    logic [7:0]      buf_q   [NUM_CHARS];
    logic [3:0]      codes_q [NUM_CHARS];
    logic [3:0]      row_q;
    logic            done_q;

    logic [IW-1:0]   pix_char_w;
    logic [2:0]      pix_bit_w;
    logic            last_pix_w;

    assign pix_char_w = IW'(pix_q >> 3);
    assign pix_bit_w  = 3'd7 - pix_q[2:0];
    assign last_pix_w = (state_q == ST_READY) && bus.PIXEL_EN && (pix_q == LAST_PIX);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pix_q   <= '0;
            row_q   <= 4'h0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_CHARS; i++) begin
                buf_q[i]   <= 8'h00;
                codes_q[i] <= 4'hF;
            end
        end else begin
            done_q <= last_pix_w;
            // A new request wins in every state, including on the last pixel.
            if (bus.LINE_START) begin
                state_q <= ST_FETCH;
                idx_q   <= '0;
                row_q   <= bus.GLYPH_ROW;
                for (int i = 0; i < NUM_CHARS; i++) begin
                    codes_q[i] <= bus.CHAR_CODES[4*i +: 4];
                end
            end else begin
                case (state_q)
                    ST_FETCH: begin
                        buf_q[idx_q] <= bus.FONT_DATA;
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_READY;
                            idx_q   <= '0;
                            pix_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (bus.PIXEL_EN) begin
                            if (pix_q == LAST_PIX) begin
                                state_q <= ST_IDLE;
                            end else begin
                                pix_q <= pix_q + 1'b1;
                            end
                        end
                    end
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.FONT_ADDR  = (state_q == ST_FETCH) ? {codes_q[idx_q], row_q} : {4'hF, row_q};
    assign bus.FETCH_BUSY = (state_q == ST_FETCH);
    assign bus.LINE_READY = (state_q == ST_READY);
    assign bus.PIXEL_ON   = (state_q == ST_READY) && buf_q[pix_char_w][pix_bit_w];
    assign bus.LINE_DONE  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_text_line_renderer.sv
// ============================================================================
// Module      : tb_text_line_renderer
// Description : Self-checking bench for text_line_renderer with a glyph ROM
//               model and a per-pixel scanline reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_text_line_renderer;

    localparam int N    = 8;
    localparam int NPIX = 8 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_line_renderer_if #(.NUM_CHARS(N)) bus ();

    logic [7:0] font [256];
    assign bus.FONT_DATA = font[bus.FONT_ADDR];

    text_line_renderer #(.NUM_CHARS(N)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0] codes [N];
    logic [3:0] row;
    logic       exp_pix [NPIX];

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [4*N-1:0] pack_codes();
        logic [4*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[4*i +: 4] = codes[i];
        return v;
    endfunction

    // Reference scanline: pixel p is bit 7-(p mod 8) of the glyph row of char p/8.
    task automatic build_model;
        logic [7:0] g;
        for (int p = 0; p < NPIX; p++) begin
            g = font[{codes[p/8], row}];
            exp_pix[p] = g[7 - (p % 8)];
        end
    endtask

    task automatic random_codes;
        for (int i = 0; i < N; i++) codes[i] = 4'($urandom_range(0, 15));
        row = 4'($urandom_range(0, 15));
    endtask

    // Drives a LINE_START pulse and returns one cycle into FETCH; inputs are then scrambled.
    task automatic start_line;
        bus.CHAR_CODES = pack_codes();
        bus.GLYPH_ROW  = row;
        bus.LINE_START = 1'b1;
        tick;
        bus.LINE_START = 1'b0;
        bus.CHAR_CODES = (4*N)'({$urandom, $urandom});
        bus.GLYPH_ROW  = 4'($urandom_range(0, 15));
        build_model;
    endtask

    task automatic finish_fetch;
        repeat (N) tick;
    endtask

    task automatic drain_line(input string tag, input int first);
        for (int p = first; p < NPIX; p++) begin
            bus.PIXEL_EN = 1'b1;
            checks++; if (bus.PIXEL_ON !== exp_pix[p]) begin errors++; $display("FAIL %s pixel %0d: got %b want %b", tag, p, bus.PIXEL_ON, exp_pix[p]); end
            checks++; if (bus.LINE_DONE !== 1'b0) begin errors++; $display("FAIL %s early_done at pixel %0d: got %b want 0", tag, p, bus.LINE_DONE); end
            tick;
        end
        bus.PIXEL_EN = 1'b0;
        checks++; if (bus.LINE_DONE !== 1'b1) begin errors++; $display("FAIL %s line_done: got %b want 1", tag, bus.LINE_DONE); end
        checks++; if ({bus.LINE_READY, bus.PIXEL_ON} !== 2'b00) begin errors++; $display("FAIL %s idle_after_line: ready/pix got %b want 00", tag, {bus.LINE_READY, bus.PIXEL_ON}); end
        tick;
        checks++; if (bus.LINE_DONE !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b want 0", tag, bus.LINE_DONE); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.LINE_START = 1'b1;
        bus.PIXEL_EN   = 1'b1;
        bus.GLYPH_ROW  = 4'h5;
        bus.CHAR_CODES = '0;
        tick; tick;
        checks++; if (bus.FONT_ADDR !== 8'hF0) begin errors++; $display("FAIL reset font_addr: got %h want f0", bus.FONT_ADDR); end
        checks++; if ({bus.FETCH_BUSY, bus.LINE_READY, bus.PIXEL_ON, bus.LINE_DONE} !== 4'b0000) begin errors++; $display("FAIL reset outputs: got %b want 0000", {bus.FETCH_BUSY, bus.LINE_READY, bus.PIXEL_ON, bus.LINE_DONE}); end
        bus.LINE_START = 1'b0;
        bus.PIXEL_EN   = 1'b0;
        rst = 1'b0;
        tick;
        checks++; if (bus.FETCH_BUSY !== 1'b0) begin errors++; $display("FAIL reset idle_after: busy got %b want 0", bus.FETCH_BUSY); end
    endtask

    task automatic test_fetch;
        logic [3:0] plan [N] = '{4'hE, 4'hA, 4'hC, 4'hD, 4'hB, 4'hF, 4'h0, 4'h1};
        for (int i = 0; i < N; i++) codes[i] = plan[i];
        row = 4'h2;
        start_line;
        for (int k = 0; k < N; k++) begin
            checks++; if (bus.FONT_ADDR !== {codes[k], row}) begin errors++; $display("FAIL fetch addr[%0d]: got %h want %h", k, bus.FONT_ADDR, {codes[k], row}); end
            checks++; if ({bus.FETCH_BUSY, bus.LINE_READY} !== 2'b10) begin errors++; $display("FAIL fetch busy[%0d]: busy/ready got %b want 10", k, {bus.FETCH_BUSY, bus.LINE_READY}); end
            tick;
        end
        checks++; if ({bus.FETCH_BUSY, bus.LINE_READY} !== 2'b01) begin errors++; $display("FAIL fetch ready_latency: busy/ready got %b want 01", {bus.FETCH_BUSY, bus.LINE_READY}); end
    endtask

    task automatic test_stream;
        logic [7:0] s_row = 8'h7C;
        for (int p = 0; p < NPIX; p++) begin
            bus.PIXEL_EN = 1'b1;
            checks++; if (bus.PIXEL_ON !== exp_pix[p]) begin errors++; $display("FAIL stream pixel %0d: got %b want %b", p, bus.PIXEL_ON, exp_pix[p]); end
            if (p < 8) begin
                checks++; if (bus.PIXEL_ON !== s_row[7-p]) begin errors++; $display("FAIL stream s_glyph %0d: got %b want %b", p, bus.PIXEL_ON, s_row[7-p]); end
            end
            if (p >= 40 && p < 48) begin
                checks++; if (bus.PIXEL_ON !== 1'b0) begin errors++; $display("FAIL stream blank %0d: got %b want 0", p, bus.PIXEL_ON); end
            end
            checks++; if (bus.LINE_DONE !== 1'b0) begin errors++; $display("FAIL stream early_done %0d: got %b want 0", p, bus.LINE_DONE); end
            tick;
        end
        bus.PIXEL_EN = 1'b0;
        checks++; if (bus.LINE_DONE !== 1'b1) begin errors++; $display("FAIL stream line_done: got %b want 1", bus.LINE_DONE); end
        checks++; if ({bus.LINE_READY, bus.FETCH_BUSY, bus.PIXEL_ON} !== 3'b000) begin errors++; $display("FAIL stream idle: got %b want 000", {bus.LINE_READY, bus.FETCH_BUSY, bus.PIXEL_ON}); end
        tick;
        checks++; if (bus.LINE_DONE !== 1'b0) begin errors++; $display("FAIL stream done_width: got %b want 0", bus.LINE_DONE); end
        bus.PIXEL_EN = 1'b1;
        tick;
        checks++; if ({bus.LINE_READY, bus.FETCH_BUSY, bus.PIXEL_ON, bus.LINE_DONE} !== 4'b0000) begin errors++; $display("FAIL stream en_in_idle: got %b want 0000", {bus.LINE_READY, bus.FETCH_BUSY, bus.PIXEL_ON, bus.LINE_DONE}); end
        bus.PIXEL_EN = 1'b0;
    endtask

    task automatic test_gapped;
        logic [7:0] one_row = 8'h7E;
        codes[0] = 4'h1;
        for (int i = 1; i < N; i++) codes[i] = 4'hF;
        row = 4'hB;
        start_line;
        finish_fetch;
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 3; c++) begin
                bus.PIXEL_EN = (c == 2);
                checks++; if (bus.PIXEL_ON !== one_row[7-p]) begin errors++; $display("FAIL gapped pixel %0d slot %0d: got %b want %b", p, c, bus.PIXEL_ON, one_row[7-p]); end
                tick;
            end
        end
        drain_line("gapped", 8);
    endtask

    task automatic test_abort;
        random_codes;
        row = 4'h2;
        start_line;
        repeat (3) tick;
        checks++; if (bus.FONT_ADDR !== {codes[3], 4'h2}) begin errors++; $display("FAIL abort pre_addr: got %h want %h", bus.FONT_ADDR, {codes[3], 4'h2}); end
        row = 4'h3;
        start_line;
        for (int k = 0; k < N; k++) begin
            checks++; if (bus.FONT_ADDR !== {codes[k], 4'h3}) begin errors++; $display("FAIL abort addr[%0d]: got %h want %h", k, bus.FONT_ADDR, {codes[k], 4'h3}); end
            checks++; if (bus.LINE_READY !== 1'b0) begin errors++; $display("FAIL abort early_ready[%0d]: got %b want 0", k, bus.LINE_READY); end
            tick;
        end
        checks++; if (bus.LINE_READY !== 1'b1) begin errors++; $display("FAIL abort ready: got %b want 1", bus.LINE_READY); end
        drain_line("abort", 0);
    endtask

    task automatic test_restart;
        random_codes;
        start_line;
        finish_fetch;
        for (int p = 0; p < NPIX - 1; p++) begin
            bus.PIXEL_EN = 1'b1;
            checks++; if (bus.PIXEL_ON !== exp_pix[p]) begin errors++; $display("FAIL last_restart pixel %0d: got %b want %b", p, bus.PIXEL_ON, exp_pix[p]); end
            tick;
        end
        random_codes;
        start_line;
        bus.PIXEL_EN = 1'b0;
        checks++; if ({bus.LINE_DONE, bus.FETCH_BUSY} !== 2'b11) begin errors++; $display("FAIL last_restart done/busy: got %b want 11", {bus.LINE_DONE, bus.FETCH_BUSY}); end
        checks++; if (bus.FONT_ADDR !== {codes[0], row}) begin errors++; $display("FAIL last_restart addr: got %h want %h", bus.FONT_ADDR, {codes[0], row}); end
        tick;
        checks++; if (bus.LINE_DONE !== 1'b0) begin errors++; $display("FAIL last_restart done_width: got %b want 0", bus.LINE_DONE); end
        repeat (N - 1) tick;
        checks++; if (bus.LINE_READY !== 1'b1) begin errors++; $display("FAIL last_restart ready: got %b want 1", bus.LINE_READY); end
        for (int p = 0; p < 20; p++) begin
            bus.PIXEL_EN = 1'b1;
            checks++; if (bus.PIXEL_ON !== exp_pix[p]) begin errors++; $display("FAIL mid_restart pixel %0d: got %b want %b", p, bus.PIXEL_ON, exp_pix[p]); end
            tick;
        end
        random_codes;
        start_line;
        bus.PIXEL_EN = 1'b0;
        for (int k = 0; k < N; k++) begin
            checks++; if ({bus.LINE_DONE, bus.FETCH_BUSY} !== 2'b01) begin errors++; $display("FAIL mid_restart done/busy[%0d]: got %b want 01", k, {bus.LINE_DONE, bus.FETCH_BUSY}); end
            tick;
        end
        checks++; if (bus.LINE_READY !== 1'b1) begin errors++; $display("FAIL mid_restart ready: got %b want 1", bus.LINE_READY); end
        drain_line("mid_restart", 0);
    endtask

    task automatic test_reset_mid_ready;
        random_codes;
        start_line;
        finish_fetch;
        bus.PIXEL_EN = 1'b1;
        repeat (10) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (bus.FONT_ADDR !== 8'hF0) begin errors++; $display("FAIL mid_reset font_addr: got %h want f0", bus.FONT_ADDR); end
        checks++; if ({bus.FETCH_BUSY, bus.LINE_READY, bus.PIXEL_ON, bus.LINE_DONE} !== 4'b0000) begin errors++; $display("FAIL mid_reset outputs: got %b want 0000", {bus.FETCH_BUSY, bus.LINE_READY, bus.PIXEL_ON, bus.LINE_DONE}); end
        for (int c = 0; c < 5; c++) begin
            bus.PIXEL_EN = c[0];
            tick;
            checks++; if ({bus.FETCH_BUSY, bus.LINE_READY, bus.PIXEL_ON, bus.LINE_DONE} !== 4'b0000) begin errors++; $display("FAIL mid_reset ignore_en[%0d]: got %b want 0000", c, {bus.FETCH_BUSY, bus.LINE_READY, bus.PIXEL_ON, bus.LINE_DONE}); end
        end
        bus.PIXEL_EN = 1'b0;
        random_codes;
        start_line;
        finish_fetch;
        drain_line("after_reset", 0);
    endtask

    task automatic test_random;
        int p;
        int budget;
        logic en;
        for (int line = 0; line < 4; line++) begin
            random_codes;
            start_line;
            for (int k = 0; k < N; k++) begin
                bus.PIXEL_EN = 1'($urandom);
                tick;
            end
            checks++; if (bus.LINE_READY !== 1'b1) begin errors++; $display("FAIL random ready line %0d: got %b want 1", line, bus.LINE_READY); end
            p = 0;
            budget = 0;
            while (p < NPIX && budget < 1000) begin
                en = 1'($urandom);
                bus.PIXEL_EN = en;
                checks++; if (bus.PIXEL_ON !== exp_pix[p]) begin errors++; $display("FAIL random line %0d pixel %0d: got %b want %b", line, p, bus.PIXEL_ON, exp_pix[p]); end
                tick;
                if (en) p++;
                budget++;
            end
            bus.PIXEL_EN = 1'b0;
            checks++; if (p != NPIX) begin errors++; $display("FAIL random budget line %0d: consumed %0d want %0d", line, p, NPIX); end
            checks++; if (bus.LINE_DONE !== 1'b1) begin errors++; $display("FAIL random line_done %0d: got %b want 1", line, bus.LINE_DONE); end
            tick;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) font[i] = 8'($urandom);
        for (int r = 0; r < 16; r++) font[8'hF0 + r] = 8'h00;
        font[8'hE2] = 8'h7C;
        font[8'h1B] = 8'h7E;
        bus.LINE_START = 1'b0;
        bus.PIXEL_EN   = 1'b0;
        bus.GLYPH_ROW  = 4'h0;
        bus.CHAR_CODES = '0;
        tick;
        test_reset;
        test_fetch;
        test_stream;
        test_gapped;
        test_abort;
        test_restart;
        test_reset_mid_ready;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
